// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// slave is the arbiter's view; master is the view of the requesters and transmitter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_busy;
   logic                      tx_done;
   logic                      grant_valid;
   logic [ID_W-1:0]           grant_id;
   logic                      err_timeout;

   modport slave (
      input  req_valid, req_data, req_last, tx_busy, tx_done,
      output req_ready, tx_start, tx_data, grant_valid, grant_id, err_timeout
   );

   modport master (
      output req_valid, req_data, req_last, tx_busy, tx_done,
      input  req_ready, tx_start, tx_data, grant_valid, grant_id, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers, with a done watchdog.
// Optional message lock (grant held until a req_last byte completes) is enabled by UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int unsigned     ID_W     = $clog2(NUM_REQ);
   localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0] WD_MAX   = '1;
   localparam logic [ID_W-1:0] PTR_RST  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
`ifdef UART_ARB_LOCK_EN
      HOLD      = 2'd3,
`endif
      WAIT_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
   logic              tx_start_q, tx_start_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              grant_valid_q, grant_valid_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic              err_timeout_q, err_timeout_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
`ifdef UART_ARB_LOCK_EN
   logic              last_q, last_d;
`endif

   int unsigned       scan_idx;
   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W-1:0]   sel_id;
   logic [NUM_REQ-1:0] ready_c;
   logic              accept;
   logic [DATA_W-1:0] sel_data;
   logic              sel_last;
   logic              wd_expired;

   // Rotating-priority scan starting just after the previous owner
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_idx = (32'(last_ptr_q) + k) % NUM_REQ;
         if (!win_found && bus.req_valid[ID_W'(scan_idx)]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(scan_idx);
         end
      end
   end

   // One-hot accept; a locked owner is the only candidate while holding
   always_comb begin
      ready_c = '0;
      sel_id  = win_idx;
`ifdef UART_ARB_LOCK_EN
      if (state_q == HOLD) sel_id = grant_id_q;
`endif
      if (rst && !bus.tx_busy) begin
         if (state_q == IDLE && win_found) ready_c[win_idx] = 1'b1;
`ifdef UART_ARB_LOCK_EN
         else if (state_q == HOLD) ready_c[grant_id_q] = bus.req_valid[grant_id_q];
`endif
      end
   end

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (sel_id == ID_W'(i)) begin
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
            sel_last = bus.req_last[i];
         end
      end
   end

   assign accept     = |(ready_c & bus.req_valid);
   assign wd_expired = (wdog_q == WD_LIMIT);

   always_comb begin
      state_d       = state_q;
      last_ptr_d    = last_ptr_q;
      tx_start_d    = 1'b0;
      tx_data_d     = tx_data_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      err_timeout_d = 1'b0;
      wdog_d        = wdog_q;
`ifdef UART_ARB_LOCK_EN
      last_d        = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               tx_data_d     = sel_data;
               grant_id_d    = sel_id;
               grant_valid_d = 1'b1;
               tx_start_d    = 1'b1;
               state_d       = LAUNCH;
`ifdef UART_ARB_LOCK_EN
               last_d        = sel_last;
`endif
            end
         end
         LAUNCH: begin
            wdog_d  = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (wdog_q != WD_MAX) wdog_d = wdog_q + WD_W'(1);
            // A done pulse on the expiry cycle still counts as success
            if (bus.tx_done) begin
               last_ptr_d = grant_id_q;
`ifdef UART_ARB_LOCK_EN
               if (last_q) begin
                  grant_valid_d = 1'b0;
                  state_d       = IDLE;
               end else begin
                  wdog_d  = '0;
                  state_d = HOLD;
               end
`else
               grant_valid_d = 1'b0;
               state_d       = IDLE;
`endif
            end else if (wd_expired) begin
               err_timeout_d = 1'b1;
               last_ptr_d    = grant_id_q;
               grant_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
`ifdef UART_ARB_LOCK_EN
         HOLD: begin
            if (wdog_q != WD_MAX) wdog_d = wdog_q + WD_W'(1);
            if (accept) begin
               tx_data_d  = sel_data;
               last_d     = sel_last;
               tx_start_d = 1'b1;
               state_d    = LAUNCH;
            end else if (wd_expired) begin
               err_timeout_d = 1'b1;
               grant_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         last_ptr_q    <= PTR_RST;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         err_timeout_q <= 1'b0;
         wdog_q        <= '0;
`ifdef UART_ARB_LOCK_EN
         last_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         last_ptr_q    <= last_ptr_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         err_timeout_q <= err_timeout_d;
         wdog_q        <= wdog_d;
`ifdef UART_ARB_LOCK_EN
         last_q        <= last_d;
`endif
      end
   end

   assign bus.req_ready   = ready_c;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps plus randomized traffic
// checked against a queue-free round-robin/lock reference model.
module tb_uart_tx_arbiter;
   localparam int unsigned NR = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int model_last;
   int model_hold;
   bit lock_en;
   logic [DW-1:0] dat [NR];
   logic [NR-1:0] lst;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic drive_data();
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = dat[i];
      bus.req_last = lst;
   endtask

   // Next owner: a locked requester keeps it, otherwise first valid after the previous owner
   function automatic int exp_winner(input logic [NR-1:0] m);
      int idx;
      if (model_hold >= 0) return model_hold;
      for (int k = 1; k <= NR; k++) begin
         idx = (model_last + k) % NR;
         if (m[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      bus.req_valid = '0;
      bus.tx_done   = 1'b0;
      bus.tx_busy   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_last = NR - 1;
      model_hold = -1;
      @(negedge clk);
   endtask

   // One complete byte: accept, launch, tx_done after lat cycles in WAIT_DONE
   task automatic do_txn(input logic [NR-1:0] m, input int lat, output int gid);
      int e;
      logic [DW-1:0] ed;
      e = exp_winner(m);
      ed = dat[e];
      bus.req_valid = m;
      drive_data();
      #1;
      check("req_ready", 32'(bus.req_ready), 32'(1) << e);
      @(negedge clk);
      check("tx_start", 32'(bus.tx_start), 32'd1);
      check("grant_id", 32'(bus.grant_id), 32'(e));
      check("tx_data", 32'(bus.tx_data), 32'(ed));
      check("grant_valid", 32'(bus.grant_valid), 32'd1);
      @(negedge clk);
      check("tx_start_pulse", 32'(bus.tx_start), 32'd0);
      repeat (lat - 1) @(negedge clk);
      check("tx_data_hold", 32'(bus.tx_data), 32'(ed));
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      check("no_err_on_done", 32'(bus.err_timeout), 32'd0);
      model_last = e;
      model_hold = (lock_en && !lst[e]) ? e : -1;
      check("grant_valid_end", 32'(bus.grant_valid), 32'(model_hold >= 0));
      gid = e;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int g;
      int cnt;
      bit seen;
      int n1;
      int ord [4];
      logic [NR-1:0] m;
`ifdef UART_ARB_LOCK_EN
      lock_en = 1'b1;
      ord = '{1, 1, 1, 0};
`else
      lock_en = 1'b0;
      ord = '{1, 0, 1, 0};
`endif
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.tx_busy   = 1'b0;
      bus.tx_done   = 1'b0;
      for (int i = 0; i < NR; i++) dat[i] = '0;
      lst = '1;

      // Reset values, with every requester valid
      rst = 1'b0;
      bus.req_valid = '1;
      repeat (2) @(negedge clk);
      check("rst_tx_start", 32'(bus.tx_start), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
      check("rst_grant_id", 32'(bus.grant_id), 32'd0);
      check("rst_err", 32'(bus.err_timeout), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = '0;
      rst = 1'b1;
      model_last = NR - 1;
      model_hold = -1;
      @(negedge clk);

      // Single request
      dat[2] = 8'hA5;
      do_txn(4'b0100, 5, g);
      bus.req_valid = '0;
      check("single_gid", 32'(bus.grant_id), 32'd2);

      // Round robin with all requesters valid
      do_reset();
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NR; i++) dat[i] = DW'($urandom);
         do_txn(4'hF, 12, g);
         check("rr_order", 32'(bus.grant_id), 32'(k % NR));
      end
      bus.req_valid = '0;

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 30; k++) begin
         m = NR'($urandom_range(1, 15));
         if (model_hold >= 0) m[model_hold] = 1'b1;
         for (int i = 0; i < NR; i++) dat[i] = DW'($urandom);
         lst = NR'($urandom);
         do_txn(m, int'($urandom_range(1, TO)), g);
      end
      bus.req_valid = '0;
      lst = '1;

      // Stray tx_done in IDLE is ignored
      do_reset();
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      @(negedge clk);
      check("stray_done_gv", 32'(bus.grant_valid), 32'd0);
      check("stray_done_start", 32'(bus.tx_start), 32'd0);

      // Busy gate
      bus.tx_busy = 1'b1;
      bus.req_valid = 4'b0001;
      dat[0] = 8'h3C;
      drive_data();
      repeat (3) begin
         #1;
         check("busy_ready", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
         check("busy_nostart", 32'(bus.tx_start), 32'd0);
      end
      bus.tx_busy = 1'b0;
      do_txn(4'b0001, 3, g);
      bus.req_valid = '0;

      // Watchdog: tx_done never returned
      do_reset();
      dat[1] = 8'h77;
      drive_data();
      bus.req_valid = 4'b0010;
      @(negedge clk);
      bus.req_valid = '0;
      check("wd_start", 32'(bus.tx_start), 32'd1);
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (bus.err_timeout) seen = 1'b1;
      end
      check("wd_seen", 32'(seen), 32'd1);
      check("wd_latency", 32'(cnt), 32'(TO + 1));
      check("wd_gv", 32'(bus.grant_valid), 32'd0);
      @(negedge clk);
      check("wd_pulse", 32'(bus.err_timeout), 32'd0);
      model_last = 1;
      model_hold = -1;
      dat[0] = 8'h5A;
      do_txn(4'b0011, 4, g);
      check("wd_next_gid", 32'(bus.grant_id), 32'd0);
      // tx_done on the expiry cycle wins
      dat[2] = 8'hC3;
      do_txn(4'b0100, TO, g);
      bus.req_valid = '0;

      // Message lock: requester 1 sends 0x10,0x11,0x12 while requester 0 stays valid
      do_reset();
      lst = '1;
      dat[0] = 8'h55;
      do_txn(4'b0001, 2, g);
      n1 = 0;
      for (int k = 0; k < 4; k++) begin
         dat[1] = DW'(8'h10 + n1);
         lst[1] = (n1 == 2);
         dat[0] = DW'($urandom);
         do_txn(4'b0011, 3, g);
         check("lock_order", 32'(bus.grant_id), 32'(ord[k]));
         if (g == 1) n1++;
      end
      bus.req_valid = '0;
      lst = '1;

      // Reset asserted during WAIT_DONE
      do_reset();
      dat[3] = 8'hEE;
      drive_data();
      bus.req_valid = 4'b1000;
      @(negedge clk);
      bus.req_valid = '0;
      repeat (3) @(negedge clk);
      bus.req_valid = '1;
      rst = 1'b0;
      #1;
      check("mid_rst_start", 32'(bus.tx_start), 32'd0);
      check("mid_rst_data", 32'(bus.tx_data), 32'd0);
      check("mid_rst_gv", 32'(bus.grant_valid), 32'd0);
      check("mid_rst_gid", 32'(bus.grant_id), 32'd0);
      check("mid_rst_err", 32'(bus.err_timeout), 32'd0);
      check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      bus.req_valid = '0;
      rst = 1'b1;
      model_last = NR - 1;
      model_hold = -1;
      @(negedge clk);
      do_txn(4'hF, 5, g);
      check("post_rst_gid", 32'(bus.grant_id), 32'd0);
      bus.req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
